// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Ports: id_* decoded ID fields in, flush in, ex_* registered EX copies out,
// pc_write / if_id_write hold strobes out; stall_cnt / flush_cnt present only
// when the ID_EX_PERF_EN macro is defined.
module id_ex_hazard_reg #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic            id_Branch,
    input  logic            id_MemRead,
    input  logic            id_MemtoReg,
    input  logic            id_MemWrite,
    input  logic            id_ALUSrc,
    input  logic            id_RegWrite,
    input  logic [1:0]      id_ALUOp,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [3:0]      id_funct,
    input  logic            flush,
    output logic            ex_valid,
    output logic            ex_Branch,
    output logic            ex_MemRead,
    output logic            ex_MemtoReg,
    output logic            ex_MemWrite,
    output logic            ex_ALUSrc,
    output logic            ex_RegWrite,
    output logic [1:0]      ex_ALUOp,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [3:0]      ex_funct,
`ifdef ID_EX_PERF_EN
    output logic [31:0]     stall_cnt,
    output logic [31:0]     flush_cnt,
`endif
    output logic            pc_write,
    output logic            if_id_write
);

    logic use_rs2;
    logic ex_load;
    logic hz;
    logic stall;
    logic bubble;

    // R-type, branch and store read rs2; I-type ALU and loads do not.
    assign use_rs2 = ~id_ALUSrc | id_MemWrite;

    // RegWrite guard keeps unknown-opcode decodes (MemRead without
    // RegWrite) from ever stalling.
    assign ex_load = ex_valid & ex_MemRead & ex_RegWrite & (ex_rd != 5'd0);

    assign hz = ex_load & id_valid &
                ((id_rs1 == ex_rd) | (use_rs2 & (id_rs2 == ex_rd)));

    // A flush wins: PC must be free to load the branch target.
    assign stall       = hz & ~flush;
    assign pc_write    = ~stall;
    assign if_id_write = ~stall;
    assign bubble      = flush | stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_Branch   <= 1'b0;
            ex_MemRead  <= 1'b0;
            ex_MemtoReg <= 1'b0;
            ex_MemWrite <= 1'b0;
            ex_ALUSrc   <= 1'b0;
            ex_RegWrite <= 1'b0;
            ex_ALUOp    <= 2'b00;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= 5'd0;
            ex_rs2      <= 5'd0;
            ex_rd       <= 5'd0;
            ex_funct    <= 4'd0;
        end else begin
            // Data fields always follow ID; in a bubble they are don't-care.
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_funct    <= id_funct;
            if (bubble) begin
                ex_valid    <= 1'b0;
                ex_Branch   <= 1'b0;
                ex_MemRead  <= 1'b0;
                ex_MemtoReg <= 1'b0;
                ex_MemWrite <= 1'b0;
                ex_ALUSrc   <= 1'b0;
                ex_RegWrite <= 1'b0;
                ex_ALUOp    <= 2'b00;
            end else begin
                ex_valid    <= id_valid;
                ex_Branch   <= id_Branch;
                ex_MemRead  <= id_MemRead;
                ex_MemtoReg <= id_MemtoReg;
                ex_MemWrite <= id_MemWrite;
                ex_ALUSrc   <= id_ALUSrc;
                ex_RegWrite <= id_RegWrite;
                ex_ALUOp    <= id_ALUOp;
            end
        end
    end

`ifdef ID_EX_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (stall) stall_cnt <= stall_cnt + 32'd1;
            if (flush) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Self-checking bench for id_ex_hazard_reg: table-driven instruction stream
// with a scoreboard of expected EX contents, plus reset-mid-stall sequence.
module tb_id_ex_hazard_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_Branch, id_MemRead, id_MemtoReg;
    logic        id_MemWrite, id_ALUSrc, id_RegWrite;
    logic [1:0]  id_ALUOp;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_funct;
    logic        flush;
    logic        ex_valid, ex_Branch, ex_MemRead, ex_MemtoReg;
    logic        ex_MemWrite, ex_ALUSrc, ex_RegWrite;
    logic [1:0]  ex_ALUOp;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [3:0]  ex_funct;
    logic        pc_write, if_id_write;
`ifdef ID_EX_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_hazard_reg #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_Branch(id_Branch),
        .id_MemRead(id_MemRead), .id_MemtoReg(id_MemtoReg),
        .id_MemWrite(id_MemWrite), .id_ALUSrc(id_ALUSrc),
        .id_RegWrite(id_RegWrite), .id_ALUOp(id_ALUOp),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_funct(id_funct), .flush(flush),
        .ex_valid(ex_valid), .ex_Branch(ex_Branch),
        .ex_MemRead(ex_MemRead), .ex_MemtoReg(ex_MemtoReg),
        .ex_MemWrite(ex_MemWrite), .ex_ALUSrc(ex_ALUSrc),
        .ex_RegWrite(ex_RegWrite), .ex_ALUOp(ex_ALUOp),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_funct(ex_funct),
`ifdef ID_EX_PERF_EN
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
        .pc_write(pc_write), .if_id_write(if_id_write)
    );

    // ctrl = {valid, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp}
    typedef struct {
        logic [8:0] ctrl;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       fl;
        logic       exp_stall;
    } vec_t;

    typedef struct {
        logic [8:0]  ctrl;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        chk_data;
    } exp_t;

    localparam logic [8:0] LW   = 9'b1_0110_1_1_00;
    localparam logic [8:0] ADD  = 9'b1_0000_0_1_10;
    localparam logic [8:0] ADDI = 9'b1_0000_1_1_10;
    localparam logic [8:0] SW   = 9'b1_0001_1_0_00;
    localparam logic [8:0] BEQ  = 9'b1_1000_0_0_01;
    localparam logic [8:0] UNK  = 9'b1_0100_0_0_00;
    localparam logic [8:0] NONE = 9'b0_0000_0_0_00;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(logic [8:0] c, logic [4:0] a, logic [4:0] b,
                                logic [4:0] d, logic f, logic s);
        vec_t v;
        v.ctrl = c; v.rs1 = a; v.rs2 = b; v.rd = d;
        v.fl = f; v.exp_stall = s;
        return v;
    endfunction

    task automatic drive(input vec_t v, input logic [31:0] pc);
        {id_valid, id_Branch, id_MemRead, id_MemtoReg,
         id_MemWrite, id_ALUSrc, id_RegWrite, id_ALUOp} = v.ctrl;
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd;
        flush = v.fl;
        id_pc = pc;
        id_imm = pc ^ 32'h5A5A_0000;
        id_rs1_data = pc + 32'd1;
        id_rs2_data = pc + 32'd2;
        id_funct = pc[5:2];
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [8:0] ex_ctrl();
        return {ex_valid, ex_Branch, ex_MemRead, ex_MemtoReg,
                ex_MemWrite, ex_ALUSrc, ex_RegWrite, ex_ALUOp};
    endfunction

    initial begin
        exp_t e;
        logic [31:0] pc;
        drive(mk(NONE, 0, 0, 0, 0, 0), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("reset_ctrl", {23'd0, ex_ctrl()}, 32'd0);
        chk("reset_pc", ex_pc, 32'd0);
        chk("reset_rd", {27'd0, ex_rd}, 32'd0);
        chk("reset_pc_write", {31'd0, pc_write}, 32'd1);
`ifdef ID_EX_PERF_EN
        chk("reset_stall_cnt", stall_cnt, 32'd0);
        chk("reset_flush_cnt", flush_cnt, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        vecs.push_back(mk(LW,   1, 0, 5, 0, 0));
        vecs.push_back(mk(ADD,  5, 7, 6, 0, 1));
        vecs.push_back(mk(ADD,  5, 7, 6, 0, 0));
        vecs.push_back(mk(LW,   2, 0, 0, 0, 0));
        vecs.push_back(mk(ADD,  0, 0, 8, 0, 0));
        vecs.push_back(mk(LW,   3, 0, 9, 0, 0));
        vecs.push_back(mk(ADDI, 4, 9, 10, 0, 0));
        vecs.push_back(mk(LW,   3, 0, 9, 0, 0));
        vecs.push_back(mk(SW,   4, 9, 0, 0, 1));
        vecs.push_back(mk(SW,   4, 9, 0, 0, 0));
        vecs.push_back(mk(UNK,  1, 0, 3, 0, 0));
        vecs.push_back(mk(ADD,  3, 3, 11, 0, 0));
        vecs.push_back(mk(LW,   1, 0, 5, 0, 0));
        vecs.push_back(mk(BEQ,  5, 5, 0, 1, 0));
        vecs.push_back(mk(LW,   1, 0, 5, 0, 0));
        vecs.push_back(mk(NONE, 5, 5, 12, 0, 0));
        vecs.push_back(mk(LW,   1, 0, 7, 0, 0));
        vecs.push_back(mk(ADD,  2, 3, 1, 0, 0));
        vecs.push_back(mk(ADD,  7, 7, 13, 0, 0));
        vecs.push_back(mk(LW,   1, 0, 5, 0, 0));
        vecs.push_back(mk(ADD,  6, 5, 14, 0, 1));
        vecs.push_back(mk(ADD,  6, 5, 14, 0, 0));
        vecs.push_back(mk(ADD,  1, 2, 15, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            pc = 32'h100 + 32'(i) * 32'd4;
            drive(vecs[i], pc);
            #1;
            chk($sformatf("pc_write[%0d]", i), {31'd0, pc_write},
                {31'd0, ~vecs[i].exp_stall});
            chk($sformatf("if_id_write[%0d]", i), {31'd0, if_id_write},
                {31'd0, ~vecs[i].exp_stall});
            if (vecs[i].fl || vecs[i].exp_stall) begin
                e.ctrl = NONE;
                e.chk_data = 1'b0;
            end else begin
                e.ctrl = vecs[i].ctrl;
                e.chk_data = vecs[i].ctrl[8];
            end
            e.rd = vecs[i].rd;
            e.pc = pc;
            e.imm = pc ^ 32'h5A5A_0000;
            sb.push_back(e);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk($sformatf("ex_ctrl[%0d]", i), {23'd0, ex_ctrl()},
                    {23'd0, e.ctrl});
                if (e.chk_data) begin
                    chk($sformatf("ex_rd[%0d]", i), {27'd0, ex_rd},
                        {27'd0, e.rd});
                    chk($sformatf("ex_pc[%0d]", i), ex_pc, e.pc);
                    chk($sformatf("ex_imm[%0d]", i), ex_imm, e.imm);
                end
            end
            @(negedge clk);
        end

`ifdef ID_EX_PERF_EN
        chk("stall_cnt", stall_cnt, 32'd3);
        chk("flush_cnt", flush_cnt, 32'd2);
`endif

        // Reset asserted while a load-use stall is pending.
        drive(mk(LW, 1, 0, 5, 0, 0), 32'h200);
        @(posedge clk);
        @(negedge clk);
        drive(mk(ADD, 5, 7, 6, 0, 1), 32'h204);
        #1;
        chk("mid_stall_pc_write", {31'd0, pc_write}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_pc_write", {31'd0, pc_write}, 32'd1);
        chk("rst_if_id_write", {31'd0, if_id_write}, 32'd1);
        chk("rst_ex_ctrl", {23'd0, ex_ctrl()}, 32'd0);
        chk("rst_ex_rd", {27'd0, ex_rd}, 32'd0);
        chk("rst_ex_pc", ex_pc, 32'd0);
        chk("rst_ex_data", ex_rs1_data | ex_rs2_data | ex_imm, 32'd0);
        chk("rst_ex_idx", {18'd0, ex_rs1, ex_rs2, ex_funct}, 32'd0);
`ifdef ID_EX_PERF_EN
        chk("rst_stall_cnt", stall_cnt, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
